// File: rtl/ascon_linear_layer_if.sv
`default_nettype none
// ============================================================================
// ascon_linear_layer_if : state/handshake bundle between the pL layer and its neighbours
// Revision: 1.0
// ============================================================================
interface ascon_linear_layer_if #(
  parameter int CWIDTH = 320
) ();
  logic [CWIDTH-1:0] c;
  logic              start;
  logic [CWIDTH-1:0] cout;
  logic              busy;
  logic              doneOut;

  modport master (
    output c,
    output start,
    input  cout,
    input  busy,
    input  doneOut
  );

  modport slave (
    input  c,
    input  start,
    output cout,
    output busy,
    output doneOut
  );
endinterface
`default_nettype wire

// File: rtl/ascon_linear_layer.sv
`default_nettype none
// ============================================================================
// ascon_linear_layer : Ascon pL diffusion layer, one 64-bit word per cycle;
//   define ASCON_LINEAR_UNROLL_EN to diffuse all five words in a single cycle.
// Revision: 1.0
// ============================================================================
module ascon_linear_layer #(
  parameter int CWIDTH = 320
) (
  input  logic                clk,
  input  logic                reset,
  ascon_linear_layer_if.slave bus
);
  localparam int NWORDS = 5;
  localparam int WW     = 64;

  if (CWIDTH != 320) begin : g_width_check
    $fatal(1, "ascon_linear_layer: CWIDTH must be 320");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [CWIDTH-1:0] in_reg, in_nxt;
  logic [CWIDTH-1:0] cout_reg, cout_nxt;
  logic [2:0]        idx, idx_nxt;
  logic              busy_reg, busy_nxt;
  logic              done_reg, done_nxt;
  logic              start_q;
  logic              start_rise;
  logic [WW-1:0]     in_word [NWORDS];

  function automatic logic [WW-1:0] rotr(input logic [WW-1:0] x, input int r);
    return (x >> r) | (x << (WW - r));
  endfunction

  function automatic logic [WW-1:0] diffuse(input logic [WW-1:0] x, input logic [2:0] i);
    logic [WW-1:0] y;
    case (i)
      3'd0:    y = x ^ rotr(x, 19) ^ rotr(x, 28);
      3'd1:    y = x ^ rotr(x, 61) ^ rotr(x, 39);
      3'd2:    y = x ^ rotr(x, 1)  ^ rotr(x, 6);
      3'd3:    y = x ^ rotr(x, 10) ^ rotr(x, 17);
      default: y = x ^ rotr(x, 7)  ^ rotr(x, 41);
    endcase
    return y;
  endfunction

  for (genvar k = 0; k < NWORDS; k++) begin : g_unpack
    assign in_word[k] = in_reg[k*WW +: WW];
  end

`ifdef ASCON_LINEAR_UNROLL_EN
  logic [WW-1:0] diff_word [NWORDS];
  for (genvar k = 0; k < NWORDS; k++) begin : g_unroll
    assign diff_word[k] = diffuse(in_word[k], 3'(k));
  end
`else
  logic [WW-1:0] shared_out;
  assign shared_out = diffuse(in_word[idx], idx);
`endif

  assign start_rise = bus.start & ~start_q;

  always_comb begin
    state_nxt = state;
    in_nxt    = in_reg;
    cout_nxt  = cout_reg;
    idx_nxt   = idx;
    busy_nxt  = busy_reg;
    done_nxt  = done_reg;
    case (state)
      IDLE, DONE: begin
        // A fresh rising edge restarts from either idle or a completed pass.
        if (start_rise) begin
          in_nxt    = bus.c;
          cout_nxt  = '0;
          idx_nxt   = 3'd0;
          busy_nxt  = 1'b1;
          done_nxt  = 1'b0;
          state_nxt = RUN;
        end
      end
      RUN: begin
`ifdef ASCON_LINEAR_UNROLL_EN
        for (int k = 0; k < NWORDS; k++) begin
          cout_nxt[k*WW +: WW] = diff_word[k];
        end
        idx_nxt   = 3'd4;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b1;
        state_nxt = DONE;
`else
        for (int k = 0; k < NWORDS; k++) begin
          if (idx == 3'(k)) begin
            cout_nxt[k*WW +: WW] = shared_out;
          end
        end
        if (idx == 3'd4) begin
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = DONE;
        end else begin
          idx_nxt = idx + 3'd1;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      in_reg   <= '0;
      cout_reg <= '0;
      idx      <= 3'd0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      in_reg   <= in_nxt;
      cout_reg <= cout_nxt;
      idx      <= idx_nxt;
      busy_reg <= busy_nxt;
      done_reg <= done_nxt;
      start_q  <= bus.start;
    end
  end

  assign bus.cout    = cout_reg;
  assign bus.busy    = busy_reg;
  assign bus.doneOut = done_reg;
endmodule
`default_nettype wire
